ccr_jump_encoder: RTL
=====================

// Module: ccr_jump_encoder
// PURPOSE
//  Producer side of the control-hazard interface. Owns the condition-code register (CCR), and encodes the EX-stage
//  instruction into the 3-bit jump code consumed by the control-hazard detector. Takes back that detector's
//  taken/flush result to clear tested flags, and keeps a shadow stack so INT/RTI preserve flags.
//  Sits in EX beside the ALU.
// PARAMETERS
//  OPC_W        5  opcode width
//  STACK_DEPTH  2  shadow-stack entries (nested interrupt depth), >=1
// PORTS
//  i_clk          in   1      clock, rising edge
//  i_rst_n        in   1      asynchronous reset, active low
//  i_valid        in   1      EX-stage instruction valid (0 during bubbles/flush)
//  i_opcode       in   OPC_W  EX-stage opcode
//  i_alu_flags    in   3      ALU result flags {C,N,Z}
//  i_alu_flags_we in   3      per-flag write enable {C,N,Z} from ALU op
//  i_hw_int_save  in   1      external-interrupt entry pulse: push CCR
//  i_taken        in   1      control-hazard detector output for current EX instruction
//  o_ex_code      out  3      jump code: 0 none, 1 JZ, 2 JN, 3 JC, 4 unconditional
//  o_flags        out  4      {0,C,N,Z}; bit0 Z, bit1 N, bit2 C, bit3 tied 0
//  o_stk_ovf      out  1      sticky: push attempted when shadow stack full
//  o_stk_unf      out  1      sticky: pop attempted when shadow stack empty
// BEHAVIOUR
//  Reset (async, i_rst_n=0): CCR=0, sp=0, stack entries=0, o_stk_ovf=o_stk_unf=0. o_ex_code is combinational.
//  Encoding (combinational, 0 latency): i_valid=0 -> 0.
//   OPC_JZ->1, OPC_JN->2, OPC_JC->3.
//   OPC_JMP/CALL/RET/INT/RTI->4.
//   Any other opcode->0.
//  o_flags = CCR register directly (no bypass); a flag written in cycle t is visible to the jump in EX at t+1.
//  CCR next-state, priority high->low, evaluated per clock when i_valid=1 unless noted:
//   1. RTI (OPC_RTI): pop. Stack non-empty -> CCR<=top, sp--. Empty -> CCR held, o_stk_unf<=1.
//   2. Taken conditional: code 1/2/3 with i_taken=1 clears tested flag only (Z/N/C). Other flags hold.
//   3. OPC_SETC -> C<=1; OPC_CLRC -> C<=0.
//   4. ALU: each flag with i_alu_flags_we bit set <= i_alu_flags bit. Same-cycle clear from rule 2 wins on that bit.
//  Push: (i_valid & OPC_INT) | i_hw_int_save. Stack[sp]<=current CCR, sp++. Full (sp==STACK_DEPTH) -> no write,
//   sp held, o_stk_ovf<=1. Both sources in one cycle count as one push.
//  Push and RTI pop same cycle: pop first (CCR<=top), then push pre-pop CCR into freed slot; sp unchanged.
//  i_taken with code 0 or 4: no CCR effect. Conditional with i_taken=0: no CCR effect.
//  Sticky errors clear only on reset. Reset mid-operation discards stack contents.
//  sp width = $clog2(STACK_DEPTH+1).
// STRUCTURE
//  Shared package ccr_pkg:
//   - Opcode constants: OPC_JZ, OPC_JN, OPC_JC, OPC_JMP, OPC_CALL, OPC_RET, OPC_INT, OPC_RTI, OPC_SETC, OPC_CLRC.
//   - Jump codes: EXC_NONE=0, EXC_JZ=1, EXC_JN=2, EXC_JC=3, EXC_UNCOND=4.
//   - Flag indices: FLG_Z=0, FLG_N=1, FLG_C=2.
//  Sub-module flags_shadow_stack (push/pop/data/full/empty, parameter STACK_DEPTH).
//   Encoder and CCR update stay in the top.
// TESTING
//  1. Reset: drive i_rst_n=0 mid-run with sp=1 -> o_flags=0, o_stk_ovf=o_stk_unf=0 immediately; next RTI sets unf.
//  2. ALU writes Z=1 (we=001) at t; JZ valid at t+1 -> o_ex_code=1, o_flags[0]=1; i_taken=1 -> Z=0 at t+2.
//  3. SETC then JC with i_taken=0 -> o_ex_code=3, C stays 1.
//     i_valid=0 with opcode JC -> o_ex_code=0.
//  4. CCR=4'b0101; INT -> push; ALU sets CCR=4'b0010; RTI -> o_flags=4'b0101, sp back to 0.
//  5. STACK_DEPTH=2: three INTs -> third sets o_stk_ovf, stack holds first two.
//     Three RTIs -> third sets o_stk_unf, CCR keeps the second pop's value.
//  6. Same cycle: JN taken with ALU we=010, N=1 -> N cleared.
//     RTI + i_hw_int_save together -> CCR<=top, pre-pop CCR stored, sp unchanged.

Source files
------------

// File: rtl/ccr_pkg.sv
// Shared constants for the condition-code register and jump-code encoder.
// Opcodes, jump codes and flag bit positions.
package ccr_pkg;

  localparam int OPC_BITS = 5;

  localparam logic [OPC_BITS-1:0] OPC_JZ   = 5'h01;
  localparam logic [OPC_BITS-1:0] OPC_JN   = 5'h02;
  localparam logic [OPC_BITS-1:0] OPC_JC   = 5'h03;
  localparam logic [OPC_BITS-1:0] OPC_JMP  = 5'h04;
  localparam logic [OPC_BITS-1:0] OPC_CALL = 5'h05;
  localparam logic [OPC_BITS-1:0] OPC_RET  = 5'h06;
  localparam logic [OPC_BITS-1:0] OPC_INT  = 5'h07;
  localparam logic [OPC_BITS-1:0] OPC_RTI  = 5'h08;
  localparam logic [OPC_BITS-1:0] OPC_SETC = 5'h09;
  localparam logic [OPC_BITS-1:0] OPC_CLRC = 5'h0a;

  localparam logic [2:0] EXC_NONE   = 3'd0;
  localparam logic [2:0] EXC_JZ     = 3'd1;
  localparam logic [2:0] EXC_JN     = 3'd2;
  localparam logic [2:0] EXC_JC     = 3'd3;
  localparam logic [2:0] EXC_UNCOND = 3'd4;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;

endpackage

// File: rtl/flags_shadow_stack.sv
// LIFO of saved {C,N,Z} flags for INT/RTI nesting.
// A simultaneous push and pop replaces the top entry in place.
module flags_shadow_stack
  import ccr_pkg::*;
#(
  parameter int STACK_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic [2:0] top,
  output logic       full,
  output logic       empty
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);

  logic [SPW-1:0] sp;
  logic [2:0]     mem [STACK_DEPTH];
  logic           do_pop;
  logic           do_push;
  logic [SPW-1:0] wr_idx;

  assign empty   = (sp == '0);
  assign full    = (sp == SPW'(STACK_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (do_pop | ~full);
  assign wr_idx  = do_pop ? sp - SPW'(1) : sp;

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (SPW'(i + 1) == sp) top = mem[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (do_push && SPW'(i) == wr_idx) mem[i] <= din;
      end
      if (do_push && !do_pop) sp <= sp + SPW'(1);
      else if (do_pop && !do_push) sp <= sp - SPW'(1);
    end
  end

endmodule

// File: rtl/ccr_jump_encoder.sv
// EX-stage jump-code encoder and condition-code register owner.
// Taken conditionals clear their tested flag; INT/RTI save and restore flags.
module ccr_jump_encoder
  import ccr_pkg::*;
#(
  parameter int OPC_W       = 5,
  parameter int STACK_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [2:0]       i_alu_flags,
  input  logic [2:0]       i_alu_flags_we,
  input  logic             i_hw_int_save,
  input  logic             i_taken,
  output logic [2:0]       o_ex_code,
  output logic [3:0]       o_flags,
  output logic             o_stk_ovf,
  output logic             o_stk_unf
);

  logic [2:0] ccr;
  logic [2:0] ccr_nxt;
  logic [2:0] stk_top;
  logic       stk_full;
  logic       stk_empty;
  logic       push;
  logic       pop;

  logic is_jz, is_jn, is_jc, is_unc;
  logic is_int, is_rti, is_setc, is_clrc;

  assign is_jz   = i_valid & (i_opcode == OPC_W'(OPC_JZ));
  assign is_jn   = i_valid & (i_opcode == OPC_W'(OPC_JN));
  assign is_jc   = i_valid & (i_opcode == OPC_W'(OPC_JC));
  assign is_int  = i_valid & (i_opcode == OPC_W'(OPC_INT));
  assign is_rti  = i_valid & (i_opcode == OPC_W'(OPC_RTI));
  assign is_setc = i_valid & (i_opcode == OPC_W'(OPC_SETC));
  assign is_clrc = i_valid & (i_opcode == OPC_W'(OPC_CLRC));
  assign is_unc  = i_valid & ((i_opcode == OPC_W'(OPC_JMP))
                 | (i_opcode == OPC_W'(OPC_CALL))
                 | (i_opcode == OPC_W'(OPC_RET))
                 | (i_opcode == OPC_W'(OPC_INT))
                 | (i_opcode == OPC_W'(OPC_RTI)));

  always_comb begin
    o_ex_code = EXC_NONE;
    unique case (1'b1)
      is_jz:   o_ex_code = EXC_JZ;
      is_jn:   o_ex_code = EXC_JN;
      is_jc:   o_ex_code = EXC_JC;
      is_unc:  o_ex_code = EXC_UNCOND;
      default: o_ex_code = EXC_NONE;
    endcase
  end

  assign push = is_int | i_hw_int_save;
  assign pop  = is_rti;

  // Lowest priority first so later assignments override earlier ones.
  always_comb begin
    ccr_nxt = ccr;
    if (i_valid) begin
      ccr_nxt = (ccr & ~i_alu_flags_we) | (i_alu_flags & i_alu_flags_we);
      if (is_setc) ccr_nxt[FLG_C] = 1'b1;
      if (is_clrc) ccr_nxt[FLG_C] = 1'b0;
      if (i_taken) begin
        unique case (1'b1)
          is_jz:   ccr_nxt[FLG_Z] = 1'b0;
          is_jn:   ccr_nxt[FLG_N] = 1'b0;
          is_jc:   ccr_nxt[FLG_C] = 1'b0;
          default: ;
        endcase
      end
      if (is_rti) ccr_nxt = stk_empty ? ccr : stk_top;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ccr       <= '0;
      o_stk_ovf <= 1'b0;
      o_stk_unf <= 1'b0;
    end else begin
      ccr <= ccr_nxt;
      if (push && stk_full && !pop) o_stk_ovf <= 1'b1;
      if (pop && stk_empty) o_stk_unf <= 1'b1;
    end
  end

  assign o_flags = {1'b0, ccr};

  flags_shadow_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (pop),
    .din   (ccr),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

endmodule
